ctrl_pipeline: RTL and testbench

Pipelined control unit for the 5-stage MIPS core. It decodes the instruction held in IF/ID into a control bundle and carries that bundle through the EX, MEM and WB stages. It detects load-use hazards and inserts bubbles, and squashes the wrong-path instruction when a branch resolves taken. It replaces the purely combinational opcode decode with a stage-aware control path.

---
 rtl/ctrl_pkg.sv | 37 +++
 rtl/ctrl_pipeline_if.sv | 38 +++
 rtl/ctrl_decode.sv | 83 ++++++++
 rtl/ctrl_pipeline.sv | 109 ++++++++++
 tb/tb_ctrl_pipeline.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcode values and the per-stage control bundle for the MIPS control pipeline.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_COP0  = 6'b010000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic zero_ext;
    logic branch;
    logic bne;
    logic jump;
    logic is_jal;
    logic illegal;
  } ctrl_t;

  localparam int    CTRL_W      = $bits(ctrl_t);
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_pipeline_if.sv
// IF/ID instruction feed, branch resolution and per-stage control outputs of ctrl_pipeline.
interface ctrl_pipeline_if
  import ctrl_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int PERF_CNT_W = 16
);
  logic                  instr_valid_i;
  logic [31:0]           instr_i;
  logic                  ex_taken_i;
  logic                  id_stall_o;
  logic                  id_flush_o;
  logic                  id_jump_o;
  ctrl_t                 ex_ctrl_o;
  ctrl_t                 mem_ctrl_o;
  ctrl_t                 wb_ctrl_o;
  logic [REG_AW-1:0]     ex_dst_o;
  logic [REG_AW-1:0]     mem_dst_o;
  logic [REG_AW-1:0]     wb_dst_o;
  logic [PERF_CNT_W-1:0] stall_cnt_o;
  logic [PERF_CNT_W-1:0] flush_cnt_o;

  modport master (
    output instr_valid_i, instr_i, ex_taken_i,
    input  id_stall_o, id_flush_o, id_jump_o,
    input  ex_ctrl_o, mem_ctrl_o, wb_ctrl_o,
    input  ex_dst_o, mem_dst_o, wb_dst_o,
    input  stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  instr_valid_i, instr_i, ex_taken_i,
    output id_stall_o, id_flush_o, id_jump_o,
    output ex_ctrl_o, mem_ctrl_o, wb_ctrl_o,
    output ex_dst_o, mem_dst_o, wb_dst_o,
    output stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational decode of the IF/ID instruction into a control bundle,
// destination register and an "rt is a source operand" flag.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int RA_REG = 31
) (
  input  logic              valid_i,
  input  logic [31:0]       instr_i,
  output ctrl_t             ctrl_o,
  output logic [REG_AW-1:0] dst_o,
  output logic              uses_rt_o
);

  logic [5:0]        op;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic              unused_bits;

  assign op          = instr_i[31:26];
  assign rt          = instr_i[16 +: REG_AW];
  assign rd          = instr_i[11 +: REG_AW];
  assign unused_bits = ^{instr_i[25:21], instr_i[10:0]};

  always_comb begin
    ctrl_o    = CTRL_BUBBLE;
    dst_o     = '0;
    uses_rt_o = 1'b0;
    if (valid_i) begin
      ctrl_o.valid = 1'b1;
      dst_o        = rt;
      case (op)
        OP_RTYPE: begin
          ctrl_o.reg_write = 1'b1;
          dst_o            = rd;
          uses_rt_o        = 1'b1;
        end
        OP_J: ctrl_o.jump = 1'b1;
        OP_JAL: begin
          ctrl_o.jump      = 1'b1;
          ctrl_o.is_jal    = 1'b1;
          ctrl_o.reg_write = 1'b1;
          dst_o            = REG_AW'(RA_REG);
        end
        OP_BEQ: begin
          ctrl_o.branch = 1'b1;
          uses_rt_o     = 1'b1;
        end
        OP_BNE: begin
          ctrl_o.branch = 1'b1;
          ctrl_o.bne    = 1'b1;
          uses_rt_o     = 1'b1;
        end
        OP_ADDI, OP_ADDIU, OP_SLTI: begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.alu_src   = 1'b1;
        end
        OP_ANDI, OP_ORI, OP_XORI: begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.alu_src   = 1'b1;
          ctrl_o.zero_ext  = 1'b1;
        end
        OP_COP0: ctrl_o.reg_write = 1'b1;
        OP_LW: begin
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.mem_read   = 1'b1;
          ctrl_o.mem_to_reg = 1'b1;
          ctrl_o.alu_src    = 1'b1;
        end
        OP_SW: begin
          ctrl_o.mem_write = 1'b1;
          ctrl_o.alu_src   = 1'b1;
          uses_rt_o        = 1'b1;
        end
        default: ctrl_o.illegal = 1'b1;
      endcase
      // $0 is hardwired, so a write to it is never architecturally visible.
      if (dst_o == '0) ctrl_o.reg_write = 1'b0;
    end
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// Stage-aware control path: ID decode -> EX/MEM/WB bundles, flush on taken branch.
// Load-use stall detection and its counter exist only when CTRL_HAZARD_EN is defined.
module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int RA_REG     = 31,
  parameter int PERF_CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  ctrl_pipeline_if.slave bus
);

  ctrl_t             dec_ctrl;
  logic [REG_AW-1:0] dec_dst;
  logic              dec_uses_rt;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              hazard;
  logic              stall;
  logic              flush;
  logic              unused_bits;

  // Index 0 = EX, 1 = MEM, 2 = WB.
  ctrl_t             stage_ctrl_q [3];
  logic [REG_AW-1:0] stage_dst_q  [3];
  ctrl_t             ex_ctrl_d;
  logic [REG_AW-1:0] ex_dst_d;

  logic [PERF_CNT_W-1:0] flush_cnt_q;
  logic [PERF_CNT_W-1:0] flush_cnt_d;

  ctrl_decode #(
    .REG_AW (REG_AW),
    .RA_REG (RA_REG)
  ) u_decode (
    .valid_i   (bus.instr_valid_i),
    .instr_i   (bus.instr_i),
    .ctrl_o    (dec_ctrl),
    .dst_o     (dec_dst),
    .uses_rt_o (dec_uses_rt)
  );

  assign id_rs = bus.instr_i[21 +: REG_AW];
  assign id_rt = bus.instr_i[16 +: REG_AW];

`ifdef CTRL_HAZARD_EN
  logic [PERF_CNT_W-1:0] stall_cnt_q;
  logic [PERF_CNT_W-1:0] stall_cnt_d;

  assign hazard = stage_ctrl_q[0].valid && stage_ctrl_q[0].mem_read &&
                  (stage_dst_q[0] != '0) &&
                  ((stage_dst_q[0] == id_rs) ||
                   (dec_uses_rt && (stage_dst_q[0] == id_rt)));
  assign stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_cnt_o = stall_cnt_q;
  assign unused_bits     = ^{bus.instr_i[31:26], bus.instr_i[15:0]};
`else
  assign hazard          = 1'b0;
  assign bus.stall_cnt_o = '0;
  assign unused_bits     = ^{bus.instr_i, id_rs, id_rt, dec_uses_rt,
                             stage_ctrl_q[0].mem_read};
`endif

  // A taken branch squashes ID, so it overrides any stall on that same slot.
  assign flush = bus.ex_taken_i;
  assign stall = hazard && !flush;

  assign ex_ctrl_d   = (stall || flush) ? CTRL_BUBBLE : dec_ctrl;
  assign ex_dst_d    = (stall || flush) ? '0 : dec_dst;
  assign flush_cnt_d = (flush && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        stage_ctrl_q[i] <= CTRL_BUBBLE;
        stage_dst_q[i]  <= '0;
      end
      flush_cnt_q <= '0;
    end else begin
      stage_ctrl_q[0] <= ex_ctrl_d;
      stage_dst_q[0]  <= ex_dst_d;
      for (int i = 1; i < 3; i++) begin
        stage_ctrl_q[i] <= stage_ctrl_q[i-1];
        stage_dst_q[i]  <= stage_dst_q[i-1];
      end
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.id_stall_o  = stall;
  assign bus.id_flush_o  = flush;
  assign bus.id_jump_o   = dec_ctrl.jump;
  assign bus.ex_ctrl_o   = stage_ctrl_q[0];
  assign bus.mem_ctrl_o  = stage_ctrl_q[1];
  assign bus.wb_ctrl_o   = stage_ctrl_q[2];
  assign bus.ex_dst_o    = stage_dst_q[0];
  assign bus.mem_dst_o   = stage_dst_q[1];
  assign bus.wb_dst_o    = stage_dst_q[2];
  assign bus.flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: a scoreboard queue holds the bundle expected in
// EX for each issued ID slot; EX/MEM/WB are compared against the last three entries.
module tb_ctrl_pipeline;
  import ctrl_pkg::*;

`ifdef CTRL_HAZARD_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  typedef struct packed {
    ctrl_t      c;
    logic [4:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ctrl_pipeline_if bus ();

  ctrl_pipeline dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_stall_cnt = 0;
  int   exp_flush_cnt = 0;

  // Instruction encodings
  localparam logic [31:0] I_ADDI8  = {OP_ADDI, 5'd0, 5'd8, 16'd5};
  localparam logic [31:0] I_LW8    = {OP_LW, 5'd9, 5'd8, 16'd0};
  localparam logic [31:0] I_LW0    = {OP_LW, 5'd9, 5'd0, 16'd0};
  localparam logic [31:0] I_ADD8   = {OP_RTYPE, 5'd8, 5'd11, 5'd10, 5'd0, 6'h20};
  localparam logic [31:0] I_ADD0   = {OP_RTYPE, 5'd0, 5'd11, 5'd10, 5'd0, 6'h20};
  localparam logic [31:0] I_SW8    = {OP_SW, 5'd9, 5'd8, 16'd4};
  localparam logic [31:0] I_BEQ    = {OP_BEQ, 5'd1, 5'd2, 16'd3};
  localparam logic [31:0] I_BNE    = {OP_BNE, 5'd3, 5'd4, 16'd7};
  localparam logic [31:0] I_ANDI   = {OP_ANDI, 5'd3, 5'd9, 16'h00ff};
  localparam logic [31:0] I_ORI0   = {OP_ORI, 5'd3, 5'd0, 16'h0001};
  localparam logic [31:0] I_J      = {OP_J, 26'h0000040};
  localparam logic [31:0] I_JAL    = {OP_JAL, 26'h0000010};
  localparam logic [31:0] I_COP0   = {OP_COP0, 5'd4, 5'd12, 16'd0};
  localparam logic [31:0] I_ILL    = {6'b111111, 5'd0, 5'd0, 16'h1234};

  function automatic ctrl_t mk(input bit rw, input bit mr, input bit mw, input bit m2r,
                               input bit asrc, input bit zext, input bit br, input bit bn,
                               input bit j, input bit jal);
    ctrl_t c;
    c            = '0;
    c.valid      = 1'b1;
    c.reg_write  = rw;
    c.mem_read   = mr;
    c.mem_write  = mw;
    c.mem_to_reg = m2r;
    c.alu_src    = asrc;
    c.zero_ext   = zext;
    c.branch     = br;
    c.bne        = bn;
    c.jump       = j;
    c.is_jal     = jal;
    return c;
  endfunction

  function automatic ctrl_t mk_ill();
    ctrl_t c;
    c         = '0;
    c.valid   = 1'b1;
    c.illegal = 1'b1;
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One ID slot: drive at negedge, check combinational outputs, clock, check stages.
  task automatic step(input string tag, input logic v, input logic [31:0] ins,
                      input logic taken, input ctrl_t ec, input logic [4:0] ed,
                      input logic est, input logic ejump);
    exp_t e;
    int   n;
    bus.instr_valid_i = v;
    bus.instr_i       = ins;
    bus.ex_taken_i    = taken;
    #1;
    check({tag, ".stall"}, 32'(bus.id_stall_o), 32'(est));
    check({tag, ".flush"}, 32'(bus.id_flush_o), 32'(taken));
    check({tag, ".jump"},  32'(bus.id_jump_o),  32'(ejump));
    e = '0;
    if (!(est || taken)) begin
      e.c = ec;
      e.d = ed;
    end
    exp_q.push_back(e);
    if (est) exp_stall_cnt++;
    if (taken) exp_flush_cnt++;
    @(posedge clk);
    @(negedge clk);
    n = exp_q.size();
    check({tag, ".ex_ctrl"},  32'(bus.ex_ctrl_o),  32'(exp_q[n-1].c));
    check({tag, ".ex_dst"},   32'(bus.ex_dst_o),   32'(exp_q[n-1].d));
    check({tag, ".mem_ctrl"}, 32'(bus.mem_ctrl_o), 32'(exp_q[n-2].c));
    check({tag, ".mem_dst"},  32'(bus.mem_dst_o),  32'(exp_q[n-2].d));
    check({tag, ".wb_ctrl"},  32'(bus.wb_ctrl_o),  32'(exp_q[n-3].c));
    check({tag, ".wb_dst"},   32'(bus.wb_dst_o),   32'(exp_q[n-3].d));
    check({tag, ".stall_cnt"}, 32'(bus.stall_cnt_o), 32'(exp_stall_cnt[15:0]));
    check({tag, ".flush_cnt"}, 32'(bus.flush_cnt_o), 32'(exp_flush_cnt[15:0]));
    while (exp_q.size() > 3) void'(exp_q.pop_front());
    $display("step %-10s v=%0b instr=%08h taken=%0b ex=%03h/%0d mem=%03h/%0d wb=%03h/%0d stall_cnt=%0d flush_cnt=%0d",
             tag, v, ins, taken, bus.ex_ctrl_o, bus.ex_dst_o, bus.mem_ctrl_o, bus.mem_dst_o,
             bus.wb_ctrl_o, bus.wb_dst_o, bus.stall_cnt_o, bus.flush_cnt_o);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".ex_valid"},  32'(bus.ex_ctrl_o.valid),  32'd0);
    check({tag, ".mem_valid"}, 32'(bus.mem_ctrl_o.valid), 32'd0);
    check({tag, ".wb_valid"},  32'(bus.wb_ctrl_o.valid),  32'd0);
    check({tag, ".ex_dst"},    32'(bus.ex_dst_o),         32'd0);
    check({tag, ".stall_cnt"}, 32'(bus.stall_cnt_o),      32'd0);
    check({tag, ".flush_cnt"}, 32'(bus.flush_cnt_o),      32'd0);
    check({tag, ".stall"},     32'(bus.id_stall_o),       32'd0);
    check({tag, ".flush"},     32'(bus.id_flush_o),       32'(bus.ex_taken_i));
    $display("reset %s ex=%03h mem=%03h wb=%03h flush=%0b", tag,
             bus.ex_ctrl_o, bus.mem_ctrl_o, bus.wb_ctrl_o, bus.id_flush_o);
  endtask

  initial begin
    ctrl_t c_addi, c_lw, c_lw0, c_rt, c_sw, c_beq, c_bne, c_andi, c_ori0, c_j, c_jal, c_cop0;
    c_addi = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    c_lw   = mk(1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    c_lw0  = mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    c_rt   = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    c_sw   = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    c_beq  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    c_bne  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    c_andi = mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    c_ori0 = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    c_j    = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    c_jal  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    c_cop0 = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    rst_n             = 1'b0;
    bus.instr_valid_i = 1'b0;
    bus.instr_i       = '0;
    bus.ex_taken_i    = 1'b0;
    exp_q             = {exp_t'(0), exp_t'(0), exp_t'(0)};
    #2;
    check_reset("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Propagation through EX/MEM/WB
    step("addi",    1, I_ADDI8, 0, c_addi, 5'd8,  0, 0);
    step("bubble",  0, 32'd0,   0, '0,     5'd0,  0, 0);
    step("bubble",  0, 32'd0,   0, '0,     5'd0,  0, 0);
    // Load-use on rs: one stall cycle, then ADD issues
    step("lw8",     1, I_LW8,   0, c_lw,   5'd8,  0, 0);
    step("add_dep", 1, I_ADD8,  0, c_rt,   5'd10, HAZ, 0);
    step("add_rep", 1, I_ADD8,  0, c_rt,   5'd10, 0, 0);
    // Loads to $0 never create a hazard
    step("lw0",     1, I_LW0,   0, c_lw0,  5'd0,  0, 0);
    step("add0",    1, I_ADD0,  0, c_rt,   5'd10, 0, 0);
    // SW reads rt
    step("lw8b",    1, I_LW8,   0, c_lw,   5'd8,  0, 0);
    step("sw_dep",  1, I_SW8,   0, c_sw,   5'd8,  HAZ, 0);
    step("sw_rep",  1, I_SW8,   0, c_sw,   5'd8,  0, 0);
    // Plain flush behind a branch
    step("beq",     1, I_BEQ,   0, c_beq,  5'd2,  0, 0);
    step("squash",  1, I_ADDI8, 1, c_addi, 5'd8,  0, 0);
    // Flush and load-use hazard together: flush wins
    step("lw8c",    1, I_LW8,   0, c_lw,   5'd8,  0, 0);
    step("flushwin",1, I_ADD8,  1, c_rt,   5'd10, 0, 0);
    step("add_aft", 1, I_ADD8,  0, c_rt,   5'd10, 0, 0);
    // Remaining opcode classes
    step("andi",    1, I_ANDI,  0, c_andi, 5'd9,  0, 0);
    step("ori0",    1, I_ORI0,  0, c_ori0, 5'd0,  0, 0);
    step("bne",     1, I_BNE,   0, c_bne,  5'd4,  0, 0);
    step("j",       1, I_J,     0, c_j,    5'd0,  0, 1);
    step("cop0",    1, I_COP0,  0, c_cop0, 5'd12, 0, 0);
    step("illegal", 1, I_ILL,   0, mk_ill(), 5'd0, 0, 0);
    step("jal",     1, I_JAL,   0, c_jal,  5'd31, 0, 1);
    step("drain",   0, 32'd0,   0, '0,     5'd0,  0, 0);
    step("drain",   0, 32'd0,   0, '0,     5'd0,  0, 0);
    step("drain",   0, 32'd0,   0, '0,     5'd0,  0, 0);

    // Asynchronous reset mid-stream with a hazard pending and a taken branch
    step("lw8d",    1, I_LW8,   0, c_lw,   5'd8,  0, 0);
    bus.instr_valid_i = 1'b1;
    bus.instr_i       = I_ADD8;
    bus.ex_taken_i    = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("mid");
    bus.ex_taken_i = 1'b0;
    exp_q          = {exp_t'(0), exp_t'(0), exp_t'(0)};
    exp_stall_cnt  = 0;
    exp_flush_cnt  = 0;
    @(negedge clk);
    rst_n = 1'b1;

    step("post_add",1, I_ADDI8, 0, c_addi, 5'd8,  0, 0);
    step("post_jal",1, I_JAL,   0, c_jal,  5'd31, 0, 1);
    step("drain",   0, 32'd0,   0, '0,     5'd0,  0, 0);
    step("drain",   0, 32'd0,   0, '0,     5'd0,  0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
